// File: rtl/pipe_stage_buf.sv
// Elastic 2-entry pipeline-stage buffer: 1-cycle latency, full throughput; in_ready comes from registered state only.
// Optional `PIPE_PERF_CNT_EN` adds saturating stall/bubble counters; without it those ports do not exist.
module pipe_stage_buf #(
  parameter int                 CTRL_W   = 4,
  parameter int                 DATA_W   = 64,
  parameter int                 INST_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = 32'h00000013,
  parameter int                 CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [INST_W-1:0] out_inst
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_nxt_state;
  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_ld_m_in;
  logic                w_ld_m_s;
  logic                w_ld_s;

  logic [CTRL_W-1:0]   r_m_ctrl;
  logic [DATA_W-1:0]   r_m_data;
  logic [INST_W-1:0]   r_m_inst;
  logic [CTRL_W-1:0]   r_s_ctrl;
  logic [DATA_W-1:0]   r_s_data;
  logic [INST_W-1:0]   r_s_inst;

  assign in_ready   = (r_state != ST_TWO);
  assign out_valid  = (r_state != ST_EMPTY);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_comb begin
    w_nxt_state = r_state;
    w_ld_m_in   = 1'b0;
    w_ld_m_s    = 1'b0;
    w_ld_s      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_nxt_state = ST_ONE;
          w_ld_m_in   = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_ld_m_in = 1'b1;
        end else if (w_in_fire) begin
          w_nxt_state = ST_TWO;
          w_ld_s      = 1'b1;
        end else if (w_out_fire) begin
          w_nxt_state = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_out_fire) begin
          w_nxt_state = ST_ONE;
          w_ld_m_s    = 1'b1;
        end
      end
      default: w_nxt_state = ST_EMPTY;
    endcase
    // A kill drops everything held plus whatever is being offered this cycle.
    if (flush) begin
      w_nxt_state = ST_EMPTY;
      w_ld_m_in   = 1'b0;
      w_ld_m_s    = 1'b0;
      w_ld_s      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_EMPTY;
      r_m_ctrl <= '0;
      r_m_data <= '0;
      r_m_inst <= NOP_INST;
      r_s_ctrl <= '0;
      r_s_data <= '0;
      r_s_inst <= NOP_INST;
    end else begin
      r_state <= w_nxt_state;
      if (w_ld_m_in) begin
        r_m_ctrl <= in_ctrl;
        r_m_data <= in_data;
        r_m_inst <= in_inst;
      end else if (w_ld_m_s) begin
        r_m_ctrl <= r_s_ctrl;
        r_m_data <= r_s_data;
        r_m_inst <= r_s_inst;
      end
      if (w_ld_s) begin
        r_s_ctrl <= in_ctrl;
        r_s_data <= in_data;
        r_s_inst <= in_inst;
      end
    end
  end

  // Stale head contents stay in M after delivery; the state alone decides what is shown.
  assign out_ctrl = out_valid ? r_m_ctrl : '0;
  assign out_data = out_valid ? r_m_data : '0;
  assign out_inst = out_valid ? r_m_inst : NOP_INST;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (!out_valid && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  // CNT_W only sizes the counters; nothing is built from it here.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboarded bench for pipe_stage_buf: directed cases plus random traffic against a queue-of-entries model.
module tb_pipe_stage_buf;

  localparam int CTRL_W = 4;
  localparam int DATA_W = 64;
  localparam int INST_W = 32;
  localparam int CNT_W  = 4;
  localparam logic [INST_W-1:0] NOP = 32'h00000013;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
    logic [INST_W-1:0] i;
  } ent_t;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [INST_W-1:0] out_inst;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;
`endif

  pipe_stage_buf #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .INST_W   (INST_W),
    .NOP_INST (NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .in_inst    (in_inst),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .out_inst   (out_inst)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_delivered = 0;

  ent_t exp_q[$];
  int   m_stall  = 0;
  int   m_bubble = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor/scoreboard: compare at negedge, then advance the model for the coming edge.
  always @(negedge clk) begin
    logic exp_vld;
    logic exp_rdy;
    ent_t ent;
    exp_vld = (exp_q.size() != 0);
    exp_rdy = (exp_q.size() < 2);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(exp_vld));
    if (exp_vld) begin
      chk("out_inst", 64'(out_inst), 64'(exp_q[0].i));
      chk("out_ctrl", 64'(out_ctrl), 64'(exp_q[0].c));
      chk("out_data", out_data, exp_q[0].d);
    end else begin
      chk("idle_inst", 64'(out_inst), 64'(NOP));
      chk("idle_ctrl", 64'(out_ctrl), 64'd0);
      chk("idle_data", out_data, 64'd0);
    end
`ifdef PIPE_PERF_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`endif
    if (rst) begin
      exp_q.delete();
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (exp_vld && !out_ready && m_stall < CNT_MAX) m_stall++;
      if (!exp_vld && m_bubble < CNT_MAX) m_bubble++;
      if (exp_vld && out_ready) n_delivered++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_vld && out_ready) void'(exp_q.pop_front());
        if (in_valid && exp_rdy) begin
          ent.c = in_ctrl;
          ent.d = in_data;
          ent.i = in_inst;
          exp_q.push_back(ent);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] inst, input logic ordy,
                     input logic fl, input logic r);
    in_valid  = v;
    in_inst   = inst;
    in_ctrl   = inst[3:0];
    in_data   = {~inst, inst};
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0; in_inst = '0;

    // Reset held two cycles
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);

    // Streaming 0x1..0x8 with downstream always ready
    for (int k = 1; k <= 8; k++) cyc(1, 32'(k), 1, 0, 0);
    base = n_delivered;
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("stream_count", 64'(n_delivered - base), 64'd1);

    // Backpressure: A, B accepted, C refused until released
    cyc(1, 32'hA, 0, 0, 0);
    cyc(1, 32'hB, 0, 0, 0);
    cyc(1, 32'hC, 0, 0, 0);
    cyc(1, 32'hC, 1, 0, 0);
    cyc(1, 32'hC, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // Flush while full with a concurrent offer
    cyc(1, 32'hA, 0, 0, 0);
    cyc(1, 32'hB, 0, 0, 0);
    cyc(1, 32'hC, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // Reset while full and stalled
    cyc(1, 32'hA, 0, 0, 0);
    cyc(1, 32'hB, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

`ifdef PIPE_PERF_CNT_EN
    // Stall counter saturates, survives flush, clears on reset
    cyc(1, 32'h20, 0, 0, 0);
    for (int k = 0; k < 20; k++) cyc(0, 0, 0, 0, 0);
    chk("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("stall_after_flush", 64'(stall_cnt), 64'(CNT_MAX));
    cyc(0, 0, 0, 0, 1);
    chk("stall_after_rst", 64'(stall_cnt), 64'd0);
    chk("bubble_after_rst", 64'(bubble_cnt), 64'd0);
`endif

    // Random traffic with occasional flush and reset
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(99) < 70);
      in_inst   = $urandom();
      in_ctrl   = CTRL_W'($urandom_range(15));
      in_data   = {$urandom(), $urandom()};
      out_ready = ($urandom_range(99) < 60);
      flush     = ($urandom_range(99) < 4);
      rst       = ($urandom_range(199) < 3);
      @(posedge clk);
      #1;
    end
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
